// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for fetch (IF) and MEM-stage ports: MEM has priority, with IF starvation protection.
// Grants are combinational and have no stall cycles. Read data returns one cycle after the grant; stores complete in the grant cycle.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_mem_req,
  input  logic        i_mem_we,
  input  logic [31:0] i_mem_addr,
  input  logic [3:0]  i_mem_wen,
  input  logic [31:0] i_mem_wdata,
  output logic        o_mem_gnt,
  output logic        o_mem_rvalid,
  output logic [31:0] o_mem_rdata,
  output logic [31:0] o_ram_addr,
  output logic [3:0]  o_ram_wen,
  output logic [31:0] o_ram_wdata,
  input  logic [31:0] i_ram_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_MEM  = 2'd2
  } resp_t;

  resp_t       r_state;
  resp_t       w_state_nxt;
  logic [3:0]  r_starve;
  logic        w_force_if;
  logic        w_if_gnt;
  logic        w_mem_gnt;

  // Grants are suppressed while reset is held so nothing reaches the RAM.
  assign w_force_if = i_if_req && (r_starve == LIMIT);
  assign w_mem_gnt  = i_mem_req && !w_force_if && !i_reset;
  assign w_if_gnt   = i_if_req && !w_mem_gnt && !i_reset;

  assign o_if_gnt  = w_if_gnt;
  assign o_mem_gnt = w_mem_gnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_starve <= 4'd0;
    end else if (w_if_gnt || !i_if_req) begin
      r_starve <= 4'd0;
    end else if (r_starve != LIMIT) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  always_comb begin
    o_ram_addr  = 32'd0;
    o_ram_wen   = 4'b0000;
    o_ram_wdata = 32'd0;
    if (w_mem_gnt) begin
      o_ram_addr  = i_mem_addr;
      o_ram_wdata = i_mem_wdata;
      o_ram_wen   = i_mem_we ? i_mem_wen : 4'b0000;
    end else if (w_if_gnt) begin
      o_ram_addr  = i_if_addr;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= RESP_NONE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = RESP_NONE;
    o_if_rvalid  = 1'b0;
    o_mem_rvalid = 1'b0;
    if (w_if_gnt) begin
      w_state_nxt = RESP_IF;
    end else if (w_mem_gnt && !i_mem_we) begin
      w_state_nxt = RESP_MEM;
    end
    case (r_state)
      RESP_IF:  o_if_rvalid  = 1'b1;
      RESP_MEM: o_mem_rvalid = 1'b1;
      default:  ;
    endcase
  end

  assign o_if_rdata  = i_ram_rdata;
  assign o_mem_rdata = i_ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter with a behavioural synchronous-read RAM.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_wen;
  logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_wen;
  logic        ram_init;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr),
    .i_mem_wen(mem_wen), .i_mem_wdata(mem_wdata),
    .o_mem_gnt(mem_gnt), .o_mem_rvalid(mem_rvalid), .o_mem_rdata(mem_rdata),
    .o_ram_addr(ram_addr), .o_ram_wen(ram_wen), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  // Behavioural RAM: one-cycle read latency, byte-enabled writes.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'd0;
      ram[10'h100] <= 32'hDEADBEEF;
      ram[10'h200] <= 32'h12345678;
      ram_rdata    <= 32'd0;
    end else begin
      ram_rdata <= ram[ram_addr[9:0]];
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) ram[ram_addr[9:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic        e_if_gnt;
    logic        e_mem_gnt;
    logic        e_if_rv;
    logic        e_mem_rv;
    logic [3:0]  e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                       input logic [31:0] ma, input logic [3:0] mwen, input logic [31:0] md);
    if_req = ir; if_addr = ia; mem_req = mr; mem_we = mw;
    mem_addr = ma; mem_wen = mwen; mem_wdata = md;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{0, 0,      0, 0, 0,      4'b0000, 0,            0, 0, 0, 0, 4'b0000, 0,      0};
    tv[1]  = '{1, 'h100,  0, 0, 0,      4'b0000, 0,            1, 0, 0, 0, 4'b0000, 'h100,  0};
    tv[2]  = '{0, 0,      0, 0, 0,      4'b0000, 0,            0, 0, 1, 0, 4'b0000, 0,      'hDEADBEEF};
    tv[3]  = '{1, 'h100,  1, 0, 'h200,  4'b0000, 0,            0, 1, 0, 0, 4'b0000, 'h200,  0};
    tv[4]  = '{1, 'h100,  0, 0, 0,      4'b0000, 0,            1, 0, 0, 1, 4'b0000, 'h100,  'h12345678};
    tv[5]  = '{0, 0,      0, 0, 0,      4'b0000, 0,            0, 0, 1, 0, 4'b0000, 0,      'hDEADBEEF};
    tv[6]  = '{0, 0,      1, 1, 'h40,   4'b0100, 'h00AB0000,   0, 1, 0, 0, 4'b0100, 'h40,   0};
    tv[7]  = '{0, 0,      1, 0, 'h40,   4'b0000, 0,            0, 1, 0, 0, 4'b0000, 'h40,   0};
    tv[8]  = '{0, 0,      0, 0, 0,      4'b0000, 0,            0, 0, 0, 1, 4'b0000, 0,      'h00AB0000};
    tv[9]  = '{0, 0,      1, 1, 'h40,   4'b0000, 'hFFFFFFFF,   0, 1, 0, 0, 4'b0000, 'h40,   0};
    tv[10] = '{1, 'h40,   0, 0, 0,      4'b0000, 0,            1, 0, 0, 0, 4'b0000, 'h40,   0};
    tv[11] = '{0, 0,      0, 0, 0,      4'b0000, 0,            0, 0, 1, 0, 4'b0000, 0,      'h00AB0000};

    drive(0, 0, 0, 0, 0, 4'b0000, 0);
    reset = 1'b1;
    ram_init = 1'b1;
    next_cycle();
    ram_init = 1'b0;
    @(negedge clk);
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_mem_gnt", {31'd0, mem_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, if_rvalid, mem_rvalid}, 32'd0);
    chk("rst_ram_wen", {28'd0, ram_wen}, 32'd0);
    next_cycle();
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].if_req, tv[i].if_addr, tv[i].mem_req, tv[i].mem_we,
            tv[i].mem_addr, tv[i].mem_wen, tv[i].mem_wdata);
      @(negedge clk);
      chk($sformatf("v%0d_if_gnt", i), {31'd0, if_gnt}, {31'd0, tv[i].e_if_gnt});
      chk($sformatf("v%0d_mem_gnt", i), {31'd0, mem_gnt}, {31'd0, tv[i].e_mem_gnt});
      chk($sformatf("v%0d_if_rvalid", i), {31'd0, if_rvalid}, {31'd0, tv[i].e_if_rv});
      chk($sformatf("v%0d_mem_rvalid", i), {31'd0, mem_rvalid}, {31'd0, tv[i].e_mem_rv});
      chk($sformatf("v%0d_ram_wen", i), {28'd0, ram_wen}, {28'd0, tv[i].e_wen});
      chk($sformatf("v%0d_ram_addr", i), ram_addr, tv[i].e_addr);
      chk($sformatf("v%0d_ram_wdata", i), ram_wdata, tv[i].e_mem_gnt ? tv[i].mem_wdata : 32'd0);
      if (tv[i].e_if_rv)  chk($sformatf("v%0d_if_rdata", i), if_rdata, tv[i].e_rdata);
      if (tv[i].e_mem_rv) chk($sformatf("v%0d_mem_rdata", i), mem_rdata, tv[i].e_rdata);
      next_cycle();
    end

    // Both requesters held: 4 MEM grants then 1 forced IF grant, repeating.
    drive(1, 'h100, 1, 0, 'h200, 4'b0000, 0);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk($sformatf("starve%0d_if_gnt", c), {31'd0, if_gnt}, {31'd0, (c % 5) == 4});
      chk($sformatf("starve%0d_mem_gnt", c), {31'd0, mem_gnt}, {31'd0, (c % 5) != 4});
      next_cycle();
    end

    // Reset pulsed while a MEM load response is due; the counter is non-zero going in.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("prerst%0d_mem_gnt", c), {31'd0, mem_gnt}, 32'd1);
      next_cycle();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("inrst_mem_rvalid", {31'd0, mem_rvalid}, 32'd0);
    chk("inrst_gnt", {30'd0, if_gnt, mem_gnt}, 32'd0);
    chk("inrst_ram_wen", {28'd0, ram_wen}, 32'd0);
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d_mem_rvalid", c), {31'd0, mem_rvalid}, {31'd0, c == 1 || c == 2 || c == 3 || c == 4});
      chk($sformatf("postrst%0d_if_gnt", c), {31'd0, if_gnt}, {31'd0, c == 4});
      chk($sformatf("postrst%0d_mem_gnt", c), {31'd0, mem_gnt}, {31'd0, c != 4});
      next_cycle();
    end

    // Idle: nothing granted, nothing written, no responses once the last read drains.
    drive(0, 0, 0, 0, 0, 4'b0000, 0);
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_all", c), {25'd0, if_gnt, mem_gnt, if_rvalid, mem_rvalid, ram_wen}, 32'd0);
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive denied IF cycles before IF receives forced priority; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  fetch-side read request; if_addr input 32: word address.
REQ-005 if_gnt  output  1  fetch request accepted this cycle; if_rvalid output 1: fetch read data valid; if_rdata output 32: fetch read data.
REQ-006 mem_req  input  1  MEM-stage request; mem_we input 1: 1=store, 0=load; mem_addr input 32; mem_wen input 4: byte enables; mem_wdata input 32.
REQ-007 mem_gnt  output  1  MEM request accepted this cycle; mem_rvalid output 1: load data valid; mem_rdata output 32: load data.
REQ-008 ram_addr  output  32; ram_wen output 4; ram_wdata output 32; ram_rdata input 32: single-port RAM with synchronous read, data returned one cycle after address.

Function
REQ-009 At most one of if_gnt and mem_gnt is 1 in any cycle; grants are combinational from the current requests and arbiter state.
REQ-010 Default priority is MEM over IF: when both requests are asserted, mem_gnt=1 unless the starvation counter has reached STARVE_LIMIT.
REQ-011 The starvation counter (4 bits) increments when if_req=1 and if_gnt=0, clears when if_gnt=1 or if_req=0, and saturates at STARVE_LIMIT.
REQ-012 Counter equal to STARVE_LIMIT with if_req=1 forces if_gnt=1 and mem_gnt=0 for that cycle; the counter clears on the next edge.
REQ-013 Granted requester drives the RAM: ram_addr equals the granted address; ram_wen equals mem_wen only for a granted MEM store (0000 for any zero byte-enable store as given); ram_wdata equals mem_wdata.
REQ-014 With no grant, ram_addr holds 0, ram_wen=0000, and ram_wdata=0.
REQ-015 Never assert ram_wen for an IF grant or a MEM load grant.
REQ-016 Response tracker FSM states RESP_NONE, RESP_IF, RESP_MEM; next state = RESP_IF after an if_gnt cycle, RESP_MEM after a mem_gnt load cycle, RESP_NONE otherwise (including after a store grant).
REQ-017 if_rvalid=1 exactly when the state is RESP_IF; mem_rvalid=1 exactly when the state is RESP_MEM; a granted read therefore returns data exactly 1 cycle after grant.
REQ-018 if_rdata and mem_rdata both equal ram_rdata combinationally; data is meaningful only while the matching rvalid is 1.
REQ-019 Stores complete in the grant cycle and produce no rvalid.
REQ-020 Back-to-back grants are allowed every cycle, including alternating requesters; a new read granted while a response is returning is legal and does not disturb it.
REQ-021 Requesters hold req/addr/data stable until granted; the arbiter does not latch ungranted requests.
REQ-022 A grant depends only on req inputs, never on rvalid state, so there are no stall cycles.

Reset
REQ-023 While reset=1: FSM=RESP_NONE, starvation counter=0, if_gnt=mem_gnt=0, if_rvalid=mem_rvalid=0, ram_wen=0000.
REQ-024 Reset asserted mid-transaction drops any in-flight read response; no rvalid appears after reset deasserts.
REQ-025 The first grant is possible in the first clk cycle after reset deasserts.

Verification
REQ-026 IF only: if_req=1, if_addr=0x100, RAM[0x100]=0xDEADBEEF -> if_gnt=1 at cycle N; if_rvalid=1 with if_rdata=0xDEADBEEF at N+1; mem_rvalid=0.
REQ-027 Simultaneous: IF read 0x100 and MEM load 0x200 in the same cycle -> mem_gnt=1 and if_gnt=0 at N; mem_rvalid at N+1; if_gnt=1 at N+1; if_rvalid at N+2.
REQ-028 Store: mem_we=1, mem_addr=0x40, mem_wen=0100, mem_wdata=0x00AB0000 -> ram_wen=0100 in the grant cycle; no rvalid follows; a subsequent load at 0x40 returns byte 2 = 0xAB.
REQ-029 Starvation: if_req and mem_req held high continuously, STARVE_LIMIT=4 -> pattern is 4 mem_gnt cycles, then 1 if_gnt, repeating; no cycle has both grants.
REQ-030 Reset mid-read: MEM load granted at N, reset pulsed during N+1 -> mem_rvalid=0 throughout and after reset, counter=0, next grant behaves as after power-up.
REQ-031 Idle: no requests -> ram_wen=0000, both gnt and both rvalid 0 for all cycles.
